jlsemi_util_clkdiv_prog: RTL and testbench



---
 rtl/jlsemi_util_clkdiv_prog_if.sv | 25 ++
 rtl/jlsemi_util_clkdiv_prog.sv | 135 +++++++++++++
 tb/tb_jlsemi_util_clkdiv_prog.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/jlsemi_util_clkdiv_prog_if.sv
// Configuration handshake and divided-clock outputs of the programmable clock divider.
// master drives requests and run enable; slave is the divider.
interface jlsemi_util_clkdiv_prog_if #(
  parameter int unsigned CNT_W = 8
);
  logic             div_en;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_phase;
  logic             cfg_load;
  logic             cfg_busy;
  logic             cfg_err;
  logic             div_tick;
  logic             clk_out;
  logic             clk_out_phase;

  modport master (
    output div_en, cfg_div, cfg_phase, cfg_load,
    input  cfg_busy, cfg_err, div_tick, clk_out, clk_out_phase
  );

  modport slave (
    input  div_en, cfg_div, cfg_phase, cfg_load,
    output cfg_busy, cfg_err, div_tick, clk_out, clk_out_phase
  );
endinterface

// File: rtl/jlsemi_util_clkdiv_prog.sv
// Runtime-programmable 50%-duty clock divider (even and odd ratios) with a phase-shifted copy.
// New ratio/phase settings are shadowed and only applied at a period boundary or while stopped.
module jlsemi_util_clkdiv_prog #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DEF_DIV   = 25,
  parameter int unsigned DEF_PHASE = 0
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  jlsemi_util_clkdiv_prog_if.slave   bus
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] act_div_q, act_div_d;
  logic [CNT_W-1:0] act_phase_q, act_phase_d;
  logic [CNT_W-1:0] shd_div_q, shd_div_d;
  logic [CNT_W-1:0] shd_phase_q, shd_phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             tick_q, tick_d;
  logic             hp_q, hp_d;
  logic             hpp_q, hpp_d;
  logic             hn_q, hnp_q;

  logic             at_end;
  logic             apply;
  logic             cfg_ok;
  logic [CNT_W-1:0] nxt;
  logic [CNT_W-1:0] half_div;
  logic [CNT_W:0]   ph_sum;
  logic [CNT_W:0]   ph_mod;

  always_comb begin
    state_d     = state_q;
    act_div_d   = act_div_q;
    act_phase_d = act_phase_q;
    shd_div_d   = shd_div_q;
    shd_phase_d = shd_phase_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    err_d       = 1'b0;
    tick_d      = 1'b0;
    hp_d        = 1'b0;
    hpp_d       = 1'b0;

    at_end = (cnt_q == (act_div_q - ONE));
    apply  = busy_q && ((state_q == ST_IDLE) || at_end);
    cfg_ok = (bus.cfg_div >= TWO) && (bus.cfg_phase < bus.cfg_div);

    // apply needs busy_q=1 and a load needs busy_q=0, so the two never collide
    if (apply) begin
      act_div_d   = shd_div_q;
      act_phase_d = shd_phase_q;
      busy_d      = 1'b0;
    end
    if (bus.cfg_load && !busy_q) begin
      if (cfg_ok) begin
        shd_div_d   = bus.cfg_div;
        shd_phase_d = bus.cfg_phase;
        busy_d      = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // next count is 0 on start and on wrap, so a freshly applied ratio begins a clean period
    nxt      = ((state_q == ST_RUN) && !at_end) ? (cnt_q + ONE) : '0;
    half_div = act_div_d >> 1;
    ph_sum   = {1'b0, nxt} + {1'b0, act_div_d} - {1'b0, act_phase_d};
    ph_mod   = (ph_sum >= {1'b0, act_div_d}) ? (ph_sum - {1'b0, act_div_d}) : ph_sum;

    if (bus.div_en) begin
      state_d = ST_RUN;
      cnt_d   = nxt;
      hp_d    = (nxt < half_div);
      hpp_d   = (ph_mod < {1'b0, half_div});
      tick_d  = (nxt == '0);
    end else begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      act_div_q   <= CNT_W'(DEF_DIV);
      act_phase_q <= CNT_W'(DEF_PHASE);
      shd_div_q   <= CNT_W'(DEF_DIV);
      shd_phase_q <= CNT_W'(DEF_PHASE);
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      tick_q      <= 1'b0;
      hp_q        <= 1'b0;
      hpp_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_div_q   <= act_div_d;
      act_phase_q <= act_phase_d;
      shd_div_q   <= shd_div_d;
      shd_phase_q <= shd_phase_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      tick_q      <= tick_d;
      hp_q        <= hp_d;
      hpp_q       <= hpp_d;
    end
  end

  // half-cycle extension for odd ratios
  always_ff @(negedge clk_in) begin
    if (rst_in) begin
      hn_q  <= 1'b0;
      hnp_q <= 1'b0;
    end else begin
      hn_q  <= hp_q;
      hnp_q <= hpp_q;
    end
  end

  assign bus.cfg_busy      = busy_q;
  assign bus.cfg_err       = err_q;
  assign bus.div_tick      = tick_q;
  assign bus.clk_out       = hp_q  | (act_div_q[0] & hn_q);
  assign bus.clk_out_phase = hpp_q | (act_div_q[0] & hnp_q);

endmodule

// File: tb/tb_jlsemi_util_clkdiv_prog.sv
// Scoreboard bench for jlsemi_util_clkdiv_prog: stimulus queues expected period shapes and
// handshake responses, a monitor measures each completed clk_out period in half-cycles.
module tb_jlsemi_util_clkdiv_prog;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jlsemi_util_clkdiv_prog_if #(.CNT_W(CNT_W)) ifc ();

  jlsemi_util_clkdiv_prog #(
    .CNT_W    (CNT_W),
    .DEF_DIV  (25),
    .DEF_PHASE(0)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  typedef struct { int n; int p; } per_t;
  typedef struct { logic err; logic busy; } rsp_t;

  per_t per_q[$];
  rsp_t rsp_q[$];

  int   checks   = 0;
  int   errors   = 0;
  int   tick_cnt = 0;
  int   hc       = 0;
  int   hi       = 0;
  int   pd       = -1;
  bit   armed    = 1'b0;
  bit   dirty    = 1'b1;
  logic prev_ph  = 1'b0;
  logic en_pos   = 1'b0;
  logic en_prev  = 1'b0;
  logic rst_pos  = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function automatic void fail(string name, string msg);
    checks++;
    errors++;
    $display("FAIL %s %s", name, msg);
  endfunction

  // one half-cycle sample of the current period
  function automatic void acc();
    if (ifc.clk_out === 1'b1) hi++;
    if (ifc.clk_out_phase === 1'b1 && prev_ph !== 1'b1 && pd < 0) pd = hc;
    prev_ph = ifc.clk_out_phase;
    hc++;
  endfunction

  // monitor / scoreboard
  initial begin
    per_t p;
    rsp_t r;
    forever begin
      @(posedge clk); #1;
      en_prev = en_pos;
      en_pos  = ifc.div_en;
      rst_pos = rst;
      if (ifc.cfg_load === 1'b1 && !rst) begin
        if (rsp_q.size() == 0) fail("rsp_queue", "actual=empty required=entry");
        else begin
          r = rsp_q.pop_front();
          chk("cfg_err_resp", 32'(ifc.cfg_err), 32'(r.err));
          chk("cfg_busy_resp", 32'(ifc.cfg_busy), 32'(r.busy));
        end
      end else begin
        chk("cfg_err_idle", 32'(ifc.cfg_err), 0);
      end
      if (!rst && en_pos && !en_prev) begin
        chk("start_tick", 32'(ifc.div_tick), 1);
        chk("start_clk_out", 32'(ifc.clk_out), 1);
      end
      if (ifc.div_tick === 1'b1) begin
        tick_cnt++;
        if (armed && !dirty) begin
          if (per_q.size() == 0) fail("per_queue", "actual=empty required=entry");
          else begin
            p = per_q.pop_front();
            chk("period_halves", hc, 2 * p.n);
            chk("high_halves", hi, p.n);
            chk("phase_delay_halves", pd, 2 * p.p);
            chk("busy_at_tick", 32'(ifc.cfg_busy), 0);
          end
        end
        armed = 1'b1;
        dirty = 1'b0;
        hc    = 0;
        hi    = 0;
        pd    = -1;
      end
      if (rst) armed = 1'b0;
      if (rst || !en_pos) dirty = 1'b1;
      acc();

      @(negedge clk); #1;
      if (rst_pos || !en_pos) begin
        chk("low_clk_out", 32'(ifc.clk_out), 0);
        chk("low_clk_out_phase", 32'(ifc.clk_out_phase), 0);
        chk("low_div_tick", 32'(ifc.div_tick), 0);
        if (rst_pos) begin
          chk("rst_busy", 32'(ifc.cfg_busy), 0);
          chk("rst_err", 32'(ifc.cfg_err), 0);
        end
      end
      acc();
    end
  end

  task automatic step();
    @(posedge clk); #3;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_ticks(input int n);
    int target = tick_cnt + n;
    int budget = 30 * n + 10;
    while (tick_cnt < target && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (tick_cnt < target) begin
      errors++;
      $display("FAIL tick_timeout actual=%0d required=%0d", tick_cnt, target);
    end
  endtask

  task automatic load(input int n, input int p, input bit e, input bit b);
    rsp_t r;
    r.err  = e;
    r.busy = b;
    rsp_q.push_back(r);
    ifc.cfg_div   = CNT_W'(n);
    ifc.cfg_phase = CNT_W'(p);
    ifc.cfg_load  = 1'b1;
    step();
    ifc.cfg_load  = 1'b0;
  endtask

  task automatic exp_per(input int n, input int p, input int k);
    per_t e;
    e.n = n;
    e.p = p;
    repeat (k) per_q.push_back(e);
  endtask

  initial begin
    ifc.div_en    = 1'b0;
    ifc.cfg_div   = '0;
    ifc.cfg_phase = '0;
    ifc.cfg_load  = 1'b0;
    steps(3);
    rst = 1'b0;
    steps(2);

    // default ratio 25
    ifc.div_en = 1'b1;
    exp_per(25, 0, 3);
    wait_ticks(4);

    // N=4 P=0 mid-period: current 25 period completes first
    steps(5);
    exp_per(25, 0, 1);
    exp_per(4, 0, 3);
    load(4, 0, 1'b0, 1'b1);
    wait_ticks(4);

    // N=7 P=3
    exp_per(4, 0, 1);
    exp_per(7, 3, 3);
    load(7, 3, 1'b0, 1'b1);
    wait_ticks(4);

    // rejected requests leave the 7/3 setting in place
    step();
    load(1, 0, 1'b1, 1'b0);
    step();
    load(6, 6, 1'b1, 1'b0);
    exp_per(7, 3, 2);
    wait_ticks(2);

    // second load while busy is ignored
    steps(2);
    load(5, 1, 1'b0, 1'b1);
    step();
    load(9, 2, 1'b0, 1'b1);
    exp_per(7, 3, 1);
    exp_per(5, 1, 2);
    wait_ticks(3);

    // disable with a simultaneous load, re-enable 5 cycles later
    steps(2);
    ifc.div_en = 1'b0;
    load(6, 0, 1'b0, 1'b1);
    steps(4);
    ifc.div_en = 1'b1;
    exp_per(6, 0, 2);
    wait_ticks(3);

    // reset mid-period with a pending request: defaults restored, shadow discarded
    steps(3);
    load(3, 1, 1'b0, 1'b1);
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    exp_per(25, 0, 2);
    wait_ticks(3);

    checks++;
    if (per_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained actual=%0d/%0d required=0/0", per_q.size(), rsp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
